keyenc_debounce: RTL and testbench
==================================

# keyenc_debounce

Parametrised successor to the 16-key priority encoder. It synchronises and debounces a vector of raw key inputs and priority-encodes the held key, with the highest index winning. It can generate auto-repeat events and delivers each press event through a valid/ack handshake with overrun detection. It sits between the board key pins and the front-panel controller, and replaces direct combinational encoding of the keys.

## Interface
- NKEYS, 16, number of key inputs (2..2^VW)
- VW, 4, width of key code; 2^VW >= NKEYS
- DB_CYCLES, 4, consecutive stable cycles needed to accept a press or release; >= 1
- CW, 16, width of debounce and repeat counters; must hold max(DB_CYCLES, REPEAT_DELAY, REPEAT_RATE)
- REPEAT_EN, 1, 1 = auto-repeat enabled, 0 = one event per press
- REPEAT_DELAY, 8, cycles from press event to first repeat event; >= 1
- REPEAT_RATE, 3, cycles between subsequent repeat events; >= 1
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- keys  input  NKEYS  raw, asynchronous key levels; 1 = pressed
- key_ack  input  1  consumer acknowledge; meaningful only while key_valid=1
- key_in  output  1  debounced "a key is held" level
- key_val  output  VW  code of the currently accepted key; holds last value after release
- key_valid  output  1  an unconsumed event is pending
- key_code  output  VW  code carried by the pending event
- overrun  output  1  sticky flag: an event was dropped while key_valid=1

## Operation
- Synchroniser: two flops per key, both reset to 0. All logic below uses the synchronised vector s.
- Encoder: any = |s. code = index of the highest set bit of s; code = 0 when any = 0.
- FSM states: IDLE, DB_PRESS, HELD, DB_REL. Reset state is IDLE. Counter cnt resets to 0.
- IDLE: if any=1, go to DB_PRESS, set cand <= code and cnt <= 0.
- DB_PRESS:
  - any=0 or code != cand: go to IDLE.
  - Otherwise, if cnt == DB_CYCLES-1: go to HELD, set key_val <= cand and key_in <= 1, raise a press event, set rep <= 0 and first <= 1.
  - Otherwise cnt++.
- HELD:
  - any=0 or code != key_val: go to DB_REL, cnt <= 0, repeat counting stops.
  - Otherwise, if REPEAT_EN=1: when rep == (first ? REPEAT_DELAY : REPEAT_RATE) - 1, raise a repeat event, set rep <= 0 and first <= 0; otherwise rep++.
- DB_REL:
  - any=1 and code == key_val: return to HELD with rep <= 0; first is unchanged and no event is raised.
  - Otherwise, if cnt == DB_CYCLES-1: go to IDLE with key_in <= 0.
  - Otherwise cnt++.
  - A different key pressed during DB_REL counts as release. It is accepted only afterwards, through IDLE and DB_PRESS.
- Event handshake, evaluated per cycle:
  - Event with key_valid=0: key_valid <= 1, key_code <= event code.
  - Event with key_valid=1 and key_ack=1: key_valid stays 1, key_code <= new code, overrun unchanged.
  - Event with key_valid=1 and key_ack=0: event dropped, key_code unchanged, overrun <= 1.
  - No event and key_ack=1: key_valid <= 0, overrun <= 0.
- Reset values: key_in=0, key_val=0, key_valid=0, key_code=0, overrun=0. Asserting reset at any time, including mid-debounce, aborts it immediately with no event.

## Timing
- All outputs are registered. There is no combinational path from keys or key_ack to any output.
- Keys stable from before edge 0: state enters DB_PRESS at edge 2.
- key_in, key_val, key_valid and key_code update at edge DB_CYCLES+2, i.e. on the (DB_CYCLES+3)th rising edge.
- Release: key_in falls DB_CYCLES+2 edges after keys go to 0, with the same accounting as press.
- Repeat events: REPEAT_DELAY edges after the press event, then every REPEAT_RATE edges while held.
- key_ack takes effect at the edge where it is sampled high; key_valid is low in the following cycle unless an event coincides.
- Glitches shorter than DB_CYCLES cycles after synchronisation never produce an event.

## Test plan
Parameters are defaults unless noted.
- Press keys=0x0021 from edge 0 and hold: key_in, key_valid = 1 and key_val, key_code = 5 at edge 6. Pulse key_ack at edge 7: key_valid = 0 after edge 7.
- Bounce: keys=0x0008 for 2 cycles, 0 for 1 cycle, then 0x0008 stable. Exactly one event with key_code=3, at edge 6 counted from the last rise.
- Repeat with ack after each event: key_valid rises at edges 6, 14, 17 and 20. With REPEAT_EN=0, only the edge-6 event occurs.
- Overrun: hold keys without acking. At edge 14, overrun=1 while key_code stays at the first event's code. Ack: key_valid=0 and overrun=0 on the next cycle.
- Priority change: hold 0x0004 (key_val=2), then switch to 0x8004. key_in falls after release debounce, then a new event with key_val=15 arrives 3+DB_CYCLES+... edges later: key_in rises again with key_code=15 and no overrun if acked.
- Reset: assert reset at edge 4 of a press. All outputs are 0 immediately, and no event is raised while reset is held.

Source files
------------

// File: rtl/keyenc_debounce.sv
// keyenc_debounce
//   Synchronises and debounces NKEYS raw key levels, priority-encodes the held
//   key (highest index wins), optionally auto-repeats, and hands each press or
//   repeat event to the consumer through a valid/ack handshake with a sticky
//   overrun flag.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   keys       raw asynchronous key levels, 1 = pressed
//   key_ack    consumer acknowledge, sampled while key_valid=1
//   key_in     debounced "a key is held" level
//   key_val    code of the accepted key; keeps its value after release
//   key_valid  an unconsumed event is pending
//   key_code   code carried by the pending event
//   overrun    sticky: an event was dropped while key_valid=1
//
// All outputs come straight from flops.
module keyenc_debounce #(
  parameter int NKEYS        = 16,
  parameter int VW           = 4,
  parameter int DB_CYCLES    = 4,
  parameter int CW           = 16,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] keys,
  input  logic             key_ack,
  output logic             key_in,
  output logic [VW-1:0]    key_val,
  output logic             key_valid,
  output logic [VW-1:0]    key_code,
  output logic             overrun
);

  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RTE_LAST = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser, one lane per key
  // --------------------------------------------------------------------------
  logic [NKEYS-1:0] meta_q;
  logic [NKEYS-1:0] s_q;

  for (genvar k = 0; k < NKEYS; k++) begin : g_sync
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_q[k] <= 1'b0;
        s_q[k]    <= 1'b0;
      end else begin
        meta_q[k] <= keys[k];
        s_q[k]    <= meta_q[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Priority encoder: later (higher) indices overwrite lower ones
  // --------------------------------------------------------------------------
  logic          any;
  logic [VW-1:0] code;

  assign any = |s_q;

  always_comb begin
    code = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (s_q[i]) code = VW'(i);
    end
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rep_q, rep_d;
  logic          first_q, first_d;
  logic [VW-1:0] cand_q, cand_d;
  logic          key_in_q, key_in_d;
  logic [VW-1:0] key_val_q, key_val_d;
  logic          key_valid_q, key_valid_d;
  logic [VW-1:0] key_code_q, key_code_d;
  logic          overrun_q, overrun_d;

  logic          ev;
  logic [VW-1:0] ev_code;
  logic [CW-1:0] rep_last;

  // First repeat waits the long delay, later ones use the rate.
  assign rep_last = first_q ? DLY_LAST : RTE_LAST;

  // Debounce / hold FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    first_d   = first_q;
    cand_d    = cand_q;
    key_in_d  = key_in_q;
    key_val_d = key_val_q;
    ev        = 1'b0;
    ev_code   = key_val_q;

    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = DB_PRESS;
          cand_d  = code;
          cnt_d   = '0;
        end
      end

      DB_PRESS: begin
        if (!any || code != cand_q) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d   = HELD;
          key_val_d = cand_q;
          key_in_d  = 1'b1;
          ev        = 1'b1;
          ev_code   = cand_q;
          rep_d     = '0;
          first_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      HELD: begin
        if (!any || code != key_val_q) begin
          state_d = DB_REL;
          cnt_d   = '0;
        end else if (REPEAT_EN != 0) begin
          if (rep_q == rep_last) begin
            ev      = 1'b1;
            rep_d   = '0;
            first_d = 1'b0;
          end else begin
            rep_d = rep_q + CW'(1);
          end
        end
      end

      DB_REL: begin
        // A bounce back to the same key resumes holding without a new event;
        // any other key counts as release and must re-debounce from IDLE.
        if (any && code == key_val_q) begin
          state_d = HELD;
          rep_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d  = IDLE;
          key_in_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Event handshake
  always_comb begin
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overrun_d   = overrun_q;
    if (ev) begin
      if (!key_valid_q) begin
        key_valid_d = 1'b1;
        key_code_d  = ev_code;
      end else if (key_ack) begin
        // old event consumed this cycle, new one takes its place
        key_code_d = ev_code;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_ack) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rep_q       <= '0;
      first_q     <= 1'b0;
      cand_q      <= '0;
      key_in_q    <= 1'b0;
      key_val_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      first_q     <= first_d;
      cand_q      <= cand_d;
      key_in_q    <= key_in_d;
      key_val_q   <= key_val_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overrun_q   <= overrun_d;
    end
  end

  assign key_in    = key_in_q;
  assign key_val   = key_val_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keyenc_debounce.sv
// Bench for keyenc_debounce with default parameters.
// Stimulus drives keys/ack/reset 2 time units after each rising edge; a
// timestamp-based reference model predicts the post-edge outputs and queues
// them; a monitor on the falling edge pops and compares.
module tb_keyenc_debounce;

  localparam int DB  = 4;
  localparam int DLY = 8;
  localparam int RTE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = '0;
  logic        key_ack = 1'b0;
  logic        key_in;
  logic [3:0]  key_val;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        overrun;

  keyenc_debounce dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keys      (keys),
    .key_ack   (key_ack),
    .key_in    (key_in),
    .key_val   (key_val),
    .key_valid (key_valid),
    .key_code  (key_code),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       kin;
    logic [3:0] val;
    logic       vld;
    logic [3:0] code;
    logic       ovr;
  } obs_t;

  obs_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [15:0] hist[$];     // keys seen at recent edges, newest first
  bit          m_in, m_pressing, m_rel, m_first;
  logic [3:0]  m_val, m_cand, m_code;
  bit          m_vld, m_ovr;
  int          m_t0, m_next_rep;
  int          cyc = 0;

  function automatic int top_bit(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic m_reset();
    hist.delete();
    m_in = 0; m_pressing = 0; m_rel = 0; m_first = 0;
    m_val = 0; m_cand = 0; m_code = 0; m_vld = 0; m_ovr = 0;
  endtask

  task automatic m_step(input logic [15:0] k, input bit ack);
    logic [15:0] s;
    bit a, ev;
    logic [3:0] c;
    hist.push_front(k);
    if (hist.size() > 3) void'(hist.pop_back());
    s  = (hist.size() == 3) ? hist[2] : 16'h0;   // two-edge synchroniser delay
    a  = (s != 0);
    c  = 4'(top_bit(s));
    ev = 0;
    if (m_in && !m_rel) begin
      if (!a || c != m_val) begin m_rel = 1; m_t0 = cyc; end
      else if (cyc == m_next_rep) begin
        ev = 1; m_first = 0; m_next_rep = cyc + RTE;
      end
    end else if (m_in) begin
      if (a && c == m_val) begin
        m_rel = 0; m_next_rep = cyc + (m_first ? DLY : RTE);
      end else if (cyc - m_t0 == DB) begin
        m_in = 0; m_rel = 0;
      end
    end else if (m_pressing) begin
      if (!a || c != m_cand) m_pressing = 0;
      else if (cyc - m_t0 == DB) begin
        m_pressing = 0; m_in = 1; m_val = m_cand; ev = 1;
        m_first = 1; m_next_rep = cyc + DLY;
      end
    end else if (a) begin
      m_pressing = 1; m_t0 = cyc; m_cand = c;
    end

    if (ev) begin
      if (!m_vld) begin m_vld = 1; m_code = m_val; end
      else if (ack) m_code = m_val;
      else m_ovr = 1;
    end else if (ack) begin
      m_vld = 0; m_ovr = 0;
    end
  endtask

  // ---------------------------------------------------------------- driver
  logic [15:0] cur_k   = '0;
  bit          cur_ack = 0;
  bit          cur_rn  = 0;

  // Handles one rising edge, then drives the values for the next one.
  task automatic tick(input logic [15:0] k, input bit ack, input bit rn);
    @(posedge clk);
    cyc++;
    if (!cur_rn) m_reset(); else m_step(cur_k, cur_ack);
    if (!rn) m_reset();   // reset asserted below clears outputs this cycle
    exp_q.push_back({m_in, m_val, m_vld, m_code, m_ovr});
    #2;
    keys = k; key_ack = ack; rst_n = rn;
    cur_k = k; cur_ack = ack; cur_rn = rn;
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      obs_t a;
      e = exp_q.pop_front();
      a = {key_in, key_val, key_valid, key_code, overrun};
      chk("cycle{in,val,vld,code,ovr}", 32'(a), 32'(e));
    end
  end

  // ---------------------------------------------------------------- stimulus
  typedef struct { logic [15:0] k; int len; } seg_t;
  seg_t dir_segs[$];

  initial begin
    logic [15:0] pat;
    int len, ackp;

    for (int i = 0; i < 3; i++) tick(16'h0, 0, 0);
    for (int i = 0; i < 3; i++) tick(16'h0, 0, 1);
    chk("reset key_valid", 32'(key_valid), 0);
    chk("reset key_val", 32'(key_val), 0);

    // press 0x0021 stable before relative edge 0
    tick(16'h0021, 0, 1);
    for (int n = 0; n <= 30; n++) begin
      tick((n >= 19) ? 16'h0 : 16'h0021, (n == 6) || (n == 17), 1);
      #1;
      case (n)
        5:  begin chk("e5 key_valid", 32'(key_valid), 0); chk("e5 key_in", 32'(key_in), 0); end
        6:  begin
              chk("e6 key_in", 32'(key_in), 1);   chk("e6 key_valid", 32'(key_valid), 1);
              chk("e6 key_val", 32'(key_val), 5); chk("e6 key_code", 32'(key_code), 5);
            end
        7:  chk("e7 ack clears", 32'(key_valid), 0);
        13: chk("e13 no repeat yet", 32'(key_valid), 0);
        14: begin chk("e14 repeat", 32'(key_valid), 1); chk("e14 overrun", 32'(overrun), 0); end
        17: begin chk("e17 overrun", 32'(overrun), 1); chk("e17 code kept", 32'(key_code), 5); end
        18: begin chk("e18 ack valid", 32'(key_valid), 0); chk("e18 ack ovr", 32'(overrun), 0); end
        20: chk("e20 repeat", 32'(key_valid), 1);
        25: chk("e25 key_in held", 32'(key_in), 1);
        26: begin chk("e26 released", 32'(key_in), 0); chk("e26 key_val kept", 32'(key_val), 5); end
        default: ;
      endcase
    end

    // bounce, priority change, reset mid-press
    dir_segs = '{'{16'h0008, 2}, '{16'h0000, 1}, '{16'h0008, 12}, '{16'h0000, 10},
                 '{16'h0004, 15}, '{16'h8004, 20}, '{16'h0000, 10}};
    foreach (dir_segs[i])
      for (int j = 0; j < dir_segs[i].len; j++) tick(dir_segs[i].k, (j % 4) == 3, 1);
    for (int j = 0; j < 4; j++) tick(16'h0002, 0, 1);
    for (int j = 0; j < 5; j++) tick(16'h0002, 0, 0);
    for (int j = 0; j < 12; j++) tick(16'h0002, j == 10, 1);
    for (int j = 0; j < 8; j++) tick(16'h0000, 1, 1);

    // randomized segments
    for (int sgi = 0; sgi < 160; sgi++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: pat = 16'h0;
        8, 9:    pat = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: pat = 16'h1 << $urandom_range(0, 15);
      endcase
      len  = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30);
      case ($urandom_range(0, 2))
        0:       ackp = 0;
        1:       ackp = 20;
        default: ackp = 60;
      endcase
      for (int j = 0; j < len; j++)
        tick(pat, $urandom_range(0, 99) < ackp, 1);
      if ($urandom_range(0, 99) < 4)
        for (int j = 0; j < $urandom_range(1, 3); j++) tick(pat, 0, 0);
    end

    for (int j = 0; j < 3; j++) tick(16'h0, 0, 1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
